// File: rtl/vedic_seq_mult.sv
// Sequential WIDTHxWIDTH unsigned multiplier sharing one vedic_2x2 core.
// Optional zero-operand bypass: define VEDIC_SEQ_ZERO_SKIP_EN.
module vedic_2x2 (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [3:0] p
);
   logic c1, c2, s1, k1, t;

   always_comb begin
      c1 = a[1] & b[0];
      c2 = a[0] & b[1];
      s1 = c1 ^ c2;
      k1 = c1 & c2;
      t  = a[1] & b[1];
      p  = {t & k1, t ^ k1, s1, a[0] & b[0]};
   end
endmodule

module vedic_seq_mult #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_product,
   output logic               busy
);
   localparam int N  = WIDTH / 2;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state, state_nx;
   logic [WIDTH-1:0] a_reg, b_reg;
   logic [PW-1:0]   acc, pp_sh, acc_nx;
   logic [IW-1:0]   i, j;
   logic [IW:0]     dsum;
   logic [1:0]      da, db;
   logic [3:0]      pp;
   logic            j_last, last, zero_op;

   vedic_2x2 u_core (
      .a (da),
      .b (db),
      .p (pp)
   );

   always_comb begin
      da     = a_reg[{i, 1'b0} +: 2];
      db     = b_reg[{j, 1'b0} +: 2];
      dsum   = {1'b0, i} + {1'b0, j};
      pp_sh  = PW'(pp) << {dsum, 1'b0};
      acc_nx = acc + pp_sh;
      j_last = (j == IW'(N - 1));
      last   = j_last && (i == IW'(N - 1));
   end

`ifdef VEDIC_SEQ_ZERO_SKIP_EN
   assign zero_op = (in_a == '0) || (in_b == '0);
`else
   assign zero_op = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (in_valid) state_nx = zero_op ? DONE : CALC;
         CALC: if (last) state_nx = DONE;
         DONE: if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Digit pair (i,j) walks row-major; the last sum lands straight in out_product.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg       <= '0;
         b_reg       <= '0;
         acc         <= '0;
         i           <= '0;
         j           <= '0;
         out_product <= '0;
      end else begin
         unique case (state)
            IDLE: if (in_valid) begin
               a_reg <= in_a;
               b_reg <= in_b;
               acc   <= '0;
               i     <= '0;
               j     <= '0;
               if (zero_op) out_product <= '0;
            end
            CALC: begin
               acc <= acc_nx;
               if (j_last) begin
                  j <= '0;
                  i <= i + 1'b1;
               end else begin
                  j <= j + 1'b1;
               end
               if (last) out_product <= acc_nx;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == CALC) || (state == DONE);
endmodule

// File: doc/vedic_seq_mult.md
# vedic_seq_mult

Sequential WIDTH×WIDTH unsigned multiplier controller that time-shares a single vedic_2x2 multiplier core. It splits each operand into 2-bit digits and schedules every digit pair through the core, one pair per cycle. It shifts and accumulates each 4-bit partial product into a 2·WIDTH result. The block sits between an operand producer and a result consumer, with valid/ready handshakes on both sides, for area-constrained datapaths where a full combinational array is too large.

## Interface
- WIDTH, 8, operand width in bits; must be even and ≥ 2; N = WIDTH/2 digits per operand
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands; high only in IDLE
- in_a  input  WIDTH  multiplicand, unsigned
- in_b  input  WIDTH  multiplier, unsigned
- out_valid  output  1  product valid; high only in DONE
- out_ready  input  1  consumer accepts product
- out_product  output  2·WIDTH  registered product
- busy  output  1  high in CALC or DONE

## Operation
- One vedic_2x2 instance is instantiated internally. Its inputs are a_reg[2i+1:2i] and b_reg[2j+1:2j]; its 4-bit output is zero-extended and added to the accumulator at shift 2·(i+j).
- States:
  - IDLE
    - in_ready=1.
    - On in_valid: latch in_a/in_b into a_reg/b_reg, clear the accumulator, set i=j=0, go to CALC.
  - CALC
    - Each cycle: acc += pp(i,j) << 2(i+j).
    - j increments. On j=N-1, j wraps to 0 and i increments.
    - After pair (N-1,N-1), go to DONE. out_product is loaded with the final accumulator value, including that last partial product.
  - DONE
    - out_valid=1, out_product held stable.
    - On out_ready, go to IDLE.
- The accumulator is 2·WIDTH bits and cannot overflow, since the maximum product is (2^WIDTH−1)^2.
- in_valid outside IDLE is ignored. The producer must hold the operands until the in handshake completes.
- out_product retains its last value after leaving DONE. Only out_valid qualifies it.
- No pipelining: exactly one operation is in flight.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_product=0, accumulator=0, i=j=0.
- rst has priority over all other activity. Reset mid-CALC or mid-DONE aborts the operation with no output handshake; the next cycle is IDLE with in_ready=1.

## Timing
- Input handshake at edge T (in_valid & in_ready).
- CALC occupies cycles T+1 … T+N².
- out_valid rises at T+N²+1. For WIDTH=8 that is T+17; for WIDTH=2 it is T+2.
- Output handshake at edge D (out_valid & out_ready). in_ready=1 from D+1.
- Minimum issue interval is N²+2 cycles.
- out_ready held high before out_valid rises completes the handshake on the first DONE cycle.
- in_ready, out_valid and busy are decoded directly from the state register, with no combinational path from in_valid/out_ready.

## Configuration
- VEDIC_SEQ_ZERO_SKIP_EN
  - Defined: at the input handshake, if in_a==0 or in_b==0, the block goes directly IDLE→DONE with out_product=0. out_valid rises at T+1 and CALC is skipped. Non-zero operands use normal timing.
  - Undefined: all operands, including zero, take the full N² CALC cycles. out_valid rises at T+N²+1.

## Test plan
- WIDTH=8, in_a=0xFF, in_b=0xFF, out_ready=1 -> out_product=0xFE01, out_valid at T+17 for exactly one cycle, in_ready back high at T+18.
- WIDTH=8, in_a=0x0D, in_b=0xB6, out_ready=0 for 5 cycles after out_valid -> out_product=0x093E held stable with out_valid=1 throughout. in_valid pulses during CALC/DONE are ignored.
- WIDTH=8, in_a=0x00, in_b=0x5A -> out_product=0x0000. With VEDIC_SEQ_ZERO_SKIP_EN, out_valid at T+1; without it, at T+17.
- rst asserted at T+6 mid-CALC (in_a=0x37, in_b=0x21) -> next cycle IDLE, in_ready=1, out_valid=0, busy=0, out_product=0. A following 0x03×0x02 yields 0x0006.
- WIDTH=2, exhaustive 4×4 operands back-to-back with random out_ready stalls -> every product matches a×b. out_valid at T+2 when out_ready=1.
- WIDTH=16, 200 random operand pairs -> each product matches a×b, with latency exactly 65 cycles from input handshake to out_valid.
